// File: rtl/msrv32_pkg.sv
// Shared state, PC-select, mcause and SYSTEM-decode constants for msrv32 trap control.
// Define WFI_EN to add the WAIT state used by the wfi stall.
package msrv32_pkg;

`ifdef WFI_EN
    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_OPERATING   = 3'd1,
        ST_TRAP_TAKEN  = 3'd2,
        ST_TRAP_RETURN = 3'd3,
        ST_WAIT        = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_OPERATING   = 3'd1,
        ST_TRAP_TAKEN  = 3'd2,
        ST_TRAP_RETURN = 3'd3
    } state_t;
`endif

    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_MEPC = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT = 2'b11;

    localparam logic [3:0] CAUSE_MISALIGNED_INSTR = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK           = 4'd3;
    localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
    localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
    localparam logic [3:0] CAUSE_ECALL            = 4'd11;
    localparam logic [3:0] CAUSE_M_SW_IRQ         = 4'd3;
    localparam logic [3:0] CAUSE_M_TIMER_IRQ      = 4'd7;
    localparam logic [3:0] CAUSE_M_EXT_IRQ        = 4'd11;

    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
    localparam logic [2:0] FUNCT3_PRIV   = 3'b000;
    localparam logic [6:0] FUNCT7_ECALL  = 7'b0000000;
    localparam logic [4:0] RS2_ECALL     = 5'd0;
    localparam logic [6:0] FUNCT7_EBREAK = 7'b0000000;
    localparam logic [4:0] RS2_EBREAK    = 5'd1;
    localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;
    localparam logic [4:0] RS2_MRET      = 5'd2;
    localparam logic [6:0] FUNCT7_WFI    = 7'b0001000;
    localparam logic [4:0] RS2_WFI       = 5'd5;

    function automatic logic is_misaligned_cause(input logic [3:0] cause);
        return (cause == CAUSE_MISALIGNED_INSTR) ||
               (cause == CAUSE_MISALIGNED_LOAD)  ||
               (cause == CAUSE_MISALIGNED_STORE);
    endfunction

    function automatic logic [1:0] pc_src_for(input state_t st);
        logic [1:0] sel;
        case (st)
            ST_RESET:       sel = PC_SRC_BOOT;
            ST_OPERATING:   sel = PC_SRC_NEXT;
            ST_TRAP_TAKEN:  sel = PC_SRC_TRAP;
            ST_TRAP_RETURN: sel = PC_SRC_MEPC;
`ifdef WFI_EN
            ST_WAIT:        sel = PC_SRC_NEXT;
`endif
            default:        sel = PC_SRC_BOOT;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/msrv32_machine_control_if.sv
// Decode-stage flags in, trap/PC control out, for msrv32_machine_control.
interface msrv32_machine_control_if;
    logic       illegal_instr_in;
    logic       misaligned_instr_in;
    logic       misaligned_load_in;
    logic       misaligned_store_in;
    logic [4:0] opcode_6_to_2_in;
    logic [2:0] funct3_in;
    logic [6:0] funct7_in;
    logic [4:0] rs2_addr_in;
    logic       mie_in;
    logic       meie_in;
    logic       mtie_in;
    logic       msie_in;
    logic       meip_in;
    logic       mtip_in;
    logic       msip_in;
    logic [1:0] pc_src_out;
    logic       flush_out;
    logic       trap_taken_out;
    logic       set_cause_out;
    logic [3:0] cause_out;
    logic       i_or_e_out;
    logic       set_epc_out;
    logic       mie_clear_out;
    logic       mie_set_out;
    logic       instret_inc_out;
    logic       misaligned_exception_out;

    modport master (
        output illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in,
               opcode_6_to_2_in, funct3_in, funct7_in, rs2_addr_in,
               mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
        input  pc_src_out, flush_out, trap_taken_out, set_cause_out, cause_out, i_or_e_out,
               set_epc_out, mie_clear_out, mie_set_out, instret_inc_out, misaligned_exception_out
    );

    modport slave (
        input  illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in,
               opcode_6_to_2_in, funct3_in, funct7_in, rs2_addr_in,
               mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
        output pc_src_out, flush_out, trap_taken_out, set_cause_out, cause_out, i_or_e_out,
               set_epc_out, mie_clear_out, mie_set_out, instret_inc_out, misaligned_exception_out
    );
endinterface

// File: rtl/msrv32_trap_priority.sv
// Combinational trap arbiter: fixed exception priority, then gated interrupt priority.
module msrv32_trap_priority
    import msrv32_pkg::*;
(
    input  logic       exc_en,
    input  logic       misaligned_instr,
    input  logic       illegal_instr,
    input  logic       ebreak,
    input  logic       misaligned_load,
    input  logic       misaligned_store,
    input  logic       ecall,
    input  logic       mie,
    input  logic       meie,
    input  logic       mtie,
    input  logic       msie,
    input  logic       meip,
    input  logic       mtip,
    input  logic       msip,
    output logic       trap_valid,
    output logic [3:0] cause,
    output logic       is_interrupt
);

    // Exceptions always win over interrupts; decode flags only count when exc_en is high.
    always_comb begin
        trap_valid   = 1'b0;
        cause        = 4'd0;
        is_interrupt = 1'b0;
        if (exc_en && misaligned_instr) begin
            trap_valid = 1'b1;
            cause      = CAUSE_MISALIGNED_INSTR;
        end else if (exc_en && illegal_instr) begin
            trap_valid = 1'b1;
            cause      = CAUSE_ILLEGAL_INSTR;
        end else if (exc_en && ebreak) begin
            trap_valid = 1'b1;
            cause      = CAUSE_EBREAK;
        end else if (exc_en && misaligned_load) begin
            trap_valid = 1'b1;
            cause      = CAUSE_MISALIGNED_LOAD;
        end else if (exc_en && misaligned_store) begin
            trap_valid = 1'b1;
            cause      = CAUSE_MISALIGNED_STORE;
        end else if (exc_en && ecall) begin
            trap_valid = 1'b1;
            cause      = CAUSE_ECALL;
        end else if (mie && meie && meip) begin
            trap_valid   = 1'b1;
            cause        = CAUSE_M_EXT_IRQ;
            is_interrupt = 1'b1;
        end else if (mie && msie && msip) begin
            trap_valid   = 1'b1;
            cause        = CAUSE_M_SW_IRQ;
            is_interrupt = 1'b1;
        end else if (mie && mtie && mtip) begin
            trap_valid   = 1'b1;
            cause        = CAUSE_M_TIMER_IRQ;
            is_interrupt = 1'b1;
        end else begin
            trap_valid   = 1'b0;
        end
    end

endmodule

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap/return sequencer for msrv32: drives PC select, CSR trap strobes and flush.
// Optional macro WFI_EN adds a WAIT state entered by wfi and left on any enabled pending interrupt.
module msrv32_machine_control
    import msrv32_pkg::*;
#(
    parameter int unsigned BOOT_HOLD = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    msrv32_machine_control_if.slave  bus
);

    localparam logic [3:0] HOLD_LAST = 4'(BOOT_HOLD - 1);

    state_t     state_r, next_state_s;
    logic [3:0] hold_cnt_r, hold_cnt_s;
    logic       latch_trap_s;
    logic       is_system_s, is_ecall_s, is_ebreak_s, is_mret_s;
    logic       exc_en_s, trap_valid_s, is_interrupt_s;
    logic [3:0] cause_s;
    logic [1:0] pc_src_r;
    logic       trap_r, flush_r, mie_set_r, misaligned_r, i_or_e_r;
    logic [3:0] cause_r;

    assign is_system_s = (bus.opcode_6_to_2_in == OPCODE_SYSTEM) && (bus.funct3_in == FUNCT3_PRIV);
    assign is_ecall_s  = is_system_s && (bus.funct7_in == FUNCT7_ECALL)  && (bus.rs2_addr_in == RS2_ECALL);
    assign is_ebreak_s = is_system_s && (bus.funct7_in == FUNCT7_EBREAK) && (bus.rs2_addr_in == RS2_EBREAK);
    assign is_mret_s   = is_system_s && (bus.funct7_in == FUNCT7_MRET)   && (bus.rs2_addr_in == RS2_MRET);
    assign exc_en_s    = (state_r == ST_OPERATING);

`ifdef WFI_EN
    logic is_wfi_s, irq_wake_s;
    assign is_wfi_s   = is_system_s && (bus.funct7_in == FUNCT7_WFI) && (bus.rs2_addr_in == RS2_WFI);
    // WAIT wakes on an enabled pending source even when global MIE is off.
    assign irq_wake_s = (bus.meie_in && bus.meip_in) || (bus.msie_in && bus.msip_in) ||
                        (bus.mtie_in && bus.mtip_in);
`endif

    msrv32_trap_priority u_trap_priority (
        .exc_en           (exc_en_s),
        .misaligned_instr (bus.misaligned_instr_in),
        .illegal_instr    (bus.illegal_instr_in),
        .ebreak           (is_ebreak_s),
        .misaligned_load  (bus.misaligned_load_in),
        .misaligned_store (bus.misaligned_store_in),
        .ecall            (is_ecall_s),
        .mie              (bus.mie_in),
        .meie             (bus.meie_in),
        .mtie             (bus.mtie_in),
        .msie             (bus.msie_in),
        .meip             (bus.meip_in),
        .mtip             (bus.mtip_in),
        .msip             (bus.msip_in),
        .trap_valid       (trap_valid_s),
        .cause            (cause_s),
        .is_interrupt     (is_interrupt_s)
    );

    // Next-state and boot-hold counter logic.
    always_comb begin
        next_state_s = state_r;
        hold_cnt_s   = hold_cnt_r;
        latch_trap_s = 1'b0;
        case (state_r)
            ST_RESET: begin
                if (hold_cnt_r >= HOLD_LAST) begin
                    next_state_s = ST_OPERATING;
                    hold_cnt_s   = 4'd0;
                end else begin
                    hold_cnt_s   = hold_cnt_r + 4'd1;
                end
            end
            ST_OPERATING: begin
                if (trap_valid_s) begin
                    next_state_s = ST_TRAP_TAKEN;
                    latch_trap_s = 1'b1;
                end else if (is_mret_s) begin
                    next_state_s = ST_TRAP_RETURN;
`ifdef WFI_EN
                end else if (is_wfi_s) begin
                    next_state_s = ST_WAIT;
`endif
                end else begin
                    next_state_s = ST_OPERATING;
                end
            end
            ST_TRAP_TAKEN:  next_state_s = ST_OPERATING;
            ST_TRAP_RETURN: next_state_s = ST_OPERATING;
`ifdef WFI_EN
            ST_WAIT: begin
                if (irq_wake_s && trap_valid_s) begin
                    next_state_s = ST_TRAP_TAKEN;
                    latch_trap_s = 1'b1;
                end else if (irq_wake_s) begin
                    next_state_s = ST_OPERATING;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
`endif
            default: begin
                next_state_s = ST_RESET;
                hold_cnt_s   = 4'd0;
            end
        endcase
    end

    // State and boot-hold counter registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r    <= ST_RESET;
            hold_cnt_r <= 4'd0;
        end else begin
            state_r    <= next_state_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    // Output registers decoded from the next state so strobes line up with the state they belong to.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pc_src_r     <= PC_SRC_BOOT;
            trap_r       <= 1'b0;
            flush_r      <= 1'b0;
            mie_set_r    <= 1'b0;
            misaligned_r <= 1'b0;
            cause_r      <= 4'd0;
            i_or_e_r     <= 1'b0;
        end else begin
            pc_src_r  <= pc_src_for(next_state_s);
            trap_r    <= latch_trap_s;
            flush_r   <= latch_trap_s || (next_state_s == ST_TRAP_RETURN);
            mie_set_r <= (next_state_s == ST_TRAP_RETURN);
            if (latch_trap_s) begin
                cause_r      <= cause_s;
                i_or_e_r     <= is_interrupt_s;
                misaligned_r <= is_misaligned_cause(cause_s) && !is_interrupt_s;
            end else begin
                cause_r      <= cause_r;
                i_or_e_r     <= i_or_e_r;
                misaligned_r <= 1'b0;
            end
        end
    end

    assign bus.pc_src_out               = pc_src_r;
    assign bus.flush_out                = flush_r;
    assign bus.trap_taken_out           = trap_r;
    assign bus.set_cause_out            = trap_r;
    assign bus.set_epc_out              = trap_r;
    assign bus.mie_clear_out            = trap_r;
    assign bus.mie_set_out              = mie_set_r;
    assign bus.cause_out                = cause_r;
    assign bus.i_or_e_out               = i_or_e_r;
    assign bus.misaligned_exception_out = misaligned_r;
    // Retire is same-cycle: an instruction that traps must not count.
    assign bus.instret_inc_out          = (state_r == ST_OPERATING) && !trap_valid_s;

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed table-driven bench for msrv32_machine_control plus reset, interrupt and wfi sequences.
module tb_msrv32_machine_control;
    import msrv32_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    msrv32_machine_control_if mc_if ();

    msrv32_machine_control #(.BOOT_HOLD(2)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (mc_if)
    );

    always #5 clk = ~clk;

    // exc = {mis_instr, illegal, mis_load, mis_store}; irq = {mie, meie, msie, mtie, meip, msip, mtip}
    typedef struct {
        logic [3:0] exc;
        logic [4:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rs2;
        logic [6:0] irq;
        logic       e_instret;
        logic [1:0] e_pc;
        logic       e_trap;
        logic       e_ret;
        logic [3:0] e_cause;
        logic       e_ie;
        logic       e_mis;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_fields(input logic [3:0] exc, input logic [4:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rs2, input logic [6:0] irq);
        mc_if.misaligned_instr_in = exc[3];
        mc_if.illegal_instr_in    = exc[2];
        mc_if.misaligned_load_in  = exc[1];
        mc_if.misaligned_store_in = exc[0];
        mc_if.opcode_6_to_2_in    = op;
        mc_if.funct3_in           = f3;
        mc_if.funct7_in           = f7;
        mc_if.rs2_addr_in         = rs2;
        mc_if.mie_in              = irq[6];
        mc_if.meie_in             = irq[5];
        mc_if.msie_in             = irq[4];
        mc_if.mtie_in             = irq[3];
        mc_if.meip_in             = irq[2];
        mc_if.msip_in             = irq[1];
        mc_if.mtip_in             = irq[0];
    endtask

    task automatic clear_inputs();
        set_fields(4'b0000, 5'd0, 3'd0, 7'd0, 5'd0, 7'b0000000);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".pc"},       32'(mc_if.pc_src_out),    32'(2'b00));
        chk({tag, ".trap"},     32'(mc_if.trap_taken_out), 32'd0);
        chk({tag, ".setcause"}, 32'(mc_if.set_cause_out),  32'd0);
        chk({tag, ".setepc"},   32'(mc_if.set_epc_out),    32'd0);
        chk({tag, ".mieclr"},   32'(mc_if.mie_clear_out),  32'd0);
        chk({tag, ".flush"},    32'(mc_if.flush_out),      32'd0);
        chk({tag, ".cause"},    32'(mc_if.cause_out),      32'd0);
        chk({tag, ".mis"},      32'(mc_if.misaligned_exception_out), 32'd0);
        chk({tag, ".instret"},  32'(mc_if.instret_inc_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            exc      op        f3    f7        rs2   irq         ins pc     trp ret cause ie  mis
        vecs[0]  = '{4'b0110, 5'd0,     3'd0, 7'h00,    5'd0, 7'b0000000, 1'b0, 2'b10, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0};
        vecs[1]  = '{4'b1100, 5'd0,     3'd0, 7'h00,    5'd0, 7'b0000000, 1'b0, 2'b10, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1};
        vecs[2]  = '{4'b0010, 5'd0,     3'd0, 7'h00,    5'd0, 7'b0000000, 1'b0, 2'b10, 1'b1, 1'b0, 4'd4,  1'b0, 1'b1};
        vecs[3]  = '{4'b0001, 5'd0,     3'd0, 7'h00,    5'd0, 7'b0000000, 1'b0, 2'b10, 1'b1, 1'b0, 4'd6,  1'b0, 1'b1};
        vecs[4]  = '{4'b0000, 5'b11100, 3'd0, 7'h00,    5'd0, 7'b0000000, 1'b0, 2'b10, 1'b1, 1'b0, 4'd11, 1'b0, 1'b0};
        vecs[5]  = '{4'b0010, 5'b11100, 3'd0, 7'h00,    5'd1, 7'b0000000, 1'b0, 2'b10, 1'b1, 1'b0, 4'd3,  1'b0, 1'b0};
        vecs[6]  = '{4'b0000, 5'd0,     3'd0, 7'h00,    5'd0, 7'b1101101, 1'b0, 2'b10, 1'b1, 1'b0, 4'd11, 1'b1, 1'b0};
        vecs[7]  = '{4'b0000, 5'd0,     3'd0, 7'h00,    5'd0, 7'b1011011, 1'b0, 2'b10, 1'b1, 1'b0, 4'd3,  1'b1, 1'b0};
        vecs[8]  = '{4'b0000, 5'd0,     3'd0, 7'h00,    5'd0, 7'b1001001, 1'b0, 2'b10, 1'b1, 1'b0, 4'd7,  1'b1, 1'b0};
        vecs[9]  = '{4'b0000, 5'd0,     3'd0, 7'h00,    5'd0, 7'b0100100, 1'b1, 2'b11, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[10] = '{4'b0000, 5'd0,     3'd0, 7'h00,    5'd0, 7'b1000100, 1'b1, 2'b11, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[11] = '{4'b0000, 5'b11100, 3'd0, 7'h00,    5'd0, 7'b1100100, 1'b0, 2'b10, 1'b1, 1'b0, 4'd11, 1'b0, 1'b0};
        vecs[12] = '{4'b0000, 5'b11100, 3'd0, 7'h18,    5'd2, 7'b0000000, 1'b1, 2'b01, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0};
        vecs[13] = '{4'b0100, 5'b11100, 3'd0, 7'h18,    5'd2, 7'b0000000, 1'b0, 2'b10, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0};
        vecs[14] = '{4'b0000, 5'b11100, 3'd1, 7'h00,    5'd0, 7'b0000000, 1'b1, 2'b11, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[15] = '{4'b0000, 5'b11100, 3'd0, 7'h18,    5'd3, 7'b0000000, 1'b1, 2'b11, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};

        // Reset and boot hold.
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("boot0.pc", 32'(mc_if.pc_src_out), 32'(2'b00));
        @(negedge clk);
        chk("boot1.pc", 32'(mc_if.pc_src_out), 32'(2'b00));
        chk("boot1.instret", 32'(mc_if.instret_inc_out), 32'd0);
        @(negedge clk);
        chk("oper.pc", 32'(mc_if.pc_src_out), 32'(2'b11));
        chk("oper.instret", 32'(mc_if.instret_inc_out), 32'd1);

        // Table of one-instruction vectors, each starting in OPERATING.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            set_fields(vecs[i].exc, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rs2, vecs[i].irq);
            @(negedge clk);
            chk($sformatf("v%0d.instret", i), 32'(mc_if.instret_inc_out), 32'(vecs[i].e_instret));
            @(posedge clk); #1;
            clear_inputs();
            @(negedge clk);
            chk($sformatf("v%0d.pc", i),       32'(mc_if.pc_src_out),     32'(vecs[i].e_pc));
            chk($sformatf("v%0d.trap", i),     32'(mc_if.trap_taken_out), 32'(vecs[i].e_trap));
            chk($sformatf("v%0d.setcause", i), 32'(mc_if.set_cause_out),  32'(vecs[i].e_trap));
            chk($sformatf("v%0d.setepc", i),   32'(mc_if.set_epc_out),    32'(vecs[i].e_trap));
            chk($sformatf("v%0d.mieclr", i),   32'(mc_if.mie_clear_out),  32'(vecs[i].e_trap));
            chk($sformatf("v%0d.flush", i),    32'(mc_if.flush_out),      32'(vecs[i].e_trap | vecs[i].e_ret));
            chk($sformatf("v%0d.mieset", i),   32'(mc_if.mie_set_out),    32'(vecs[i].e_ret));
            if (vecs[i].e_trap) begin
                chk($sformatf("v%0d.cause", i), 32'(mc_if.cause_out),  32'(vecs[i].e_cause));
                chk($sformatf("v%0d.ie", i),    32'(mc_if.i_or_e_out), 32'(vecs[i].e_ie));
                chk($sformatf("v%0d.mis", i),   32'(mc_if.misaligned_exception_out), 32'(vecs[i].e_mis));
            end
        end

        // External interrupt: single-cycle mie_clear, then cause/i_or_e held.
        @(posedge clk); #1 set_fields(4'b0000, 5'd0, 3'd0, 7'h00, 5'd0, 7'b1101101);
        @(posedge clk); #1 clear_inputs();
        @(negedge clk);
        chk("irq.mieclr", 32'(mc_if.mie_clear_out), 32'd1);
        chk("irq.cause",  32'(mc_if.cause_out),     32'd11);
        @(negedge clk);
        chk("irq.mieclr_drop", 32'(mc_if.mie_clear_out), 32'd0);
        chk("irq.cause_hold",  32'(mc_if.cause_out),     32'd11);
        chk("irq.ie_hold",     32'(mc_if.i_or_e_out),    32'd1);
        chk("irq.pc_next",     32'(mc_if.pc_src_out),    32'(2'b11));

        // Interrupt raised during TRAP_TAKEN waits for OPERATING.
        @(posedge clk); #1 set_fields(4'b0100, 5'd0, 3'd0, 7'h00, 5'd0, 7'b0000000);
        @(posedge clk); #1 set_fields(4'b0000, 5'd0, 3'd0, 7'h00, 5'd0, 7'b1001001);
        @(negedge clk);
        chk("late.trap1",  32'(mc_if.trap_taken_out), 32'd1);
        chk("late.cause1", 32'(mc_if.cause_out),      32'd2);
        @(negedge clk);
        chk("late.oper_trap", 32'(mc_if.trap_taken_out), 32'd0);
        chk("late.oper_pc",   32'(mc_if.pc_src_out),     32'(2'b11));
        chk("late.instret",   32'(mc_if.instret_inc_out), 32'd0);
        @(posedge clk); #1 clear_inputs();
        @(negedge clk);
        chk("late.trap2",  32'(mc_if.trap_taken_out), 32'd1);
        chk("late.cause2", 32'(mc_if.cause_out),      32'd7);
        chk("late.ie2",    32'(mc_if.i_or_e_out),     32'd1);

        // Asynchronous reset in the middle of TRAP_TAKEN.
        @(posedge clk); #1 set_fields(4'b0001, 5'd0, 3'd0, 7'h00, 5'd0, 7'b0000000);
        @(posedge clk); #1 clear_inputs();
        @(negedge clk);
        chk("mid.trap", 32'(mc_if.trap_taken_out), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_idle("mid_rst");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid.boot_pc", 32'(mc_if.pc_src_out), 32'(2'b00));
        @(negedge clk);
        @(negedge clk);
        chk("mid.oper_pc",      32'(mc_if.pc_src_out),      32'(2'b11));
        chk("mid.oper_instret", 32'(mc_if.instret_inc_out), 32'd1);

`ifdef WFI_EN
        // wfi stalls in WAIT until mtip arrives, then traps with the timer cause.
        @(posedge clk); #1 set_fields(4'b0000, 5'b11100, 3'd0, 7'h08, 5'd5, 7'b0000000);
        @(posedge clk); #1 set_fields(4'b0000, 5'd0, 3'd0, 7'h00, 5'd0, 7'b1001000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("wait%0d.instret", k), 32'(mc_if.instret_inc_out), 32'd0);
            chk($sformatf("wait%0d.pc", k),      32'(mc_if.pc_src_out),      32'(2'b11));
            chk($sformatf("wait%0d.flush", k),   32'(mc_if.flush_out),       32'd0);
            chk($sformatf("wait%0d.trap", k),    32'(mc_if.trap_taken_out),  32'd0);
        end
        mc_if.mtip_in = 1'b1;
        @(negedge clk);
        chk("wfi.trap",  32'(mc_if.trap_taken_out), 32'd1);
        chk("wfi.cause", 32'(mc_if.cause_out),      32'd7);
        chk("wfi.ie",    32'(mc_if.i_or_e_out),     32'd1);
        chk("wfi.pc",    32'(mc_if.pc_src_out),     32'(2'b10));
        @(posedge clk); #1 clear_inputs();
`else
        // wfi without the WAIT state retires as a NOP.
        @(posedge clk); #1 set_fields(4'b0000, 5'b11100, 3'd0, 7'h08, 5'd5, 7'b0000000);
        @(negedge clk);
        chk("wfi.instret", 32'(mc_if.instret_inc_out), 32'd1);
        @(posedge clk); #1 clear_inputs();
        @(negedge clk);
        chk("wfi.pc",    32'(mc_if.pc_src_out),     32'(2'b11));
        chk("wfi.flush", 32'(mc_if.flush_out),      32'd0);
        chk("wfi.trap",  32'(mc_if.trap_taken_out), 32'd0);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
